ahbl_req_manager: RTL

- AHB-lite manager (initiator) that turns a simple valid/ready request stream into single NONSEQ transfers, with full address/data phase pipelining.
- Returns one response per request, in order: read data or write acknowledge, plus an error flag.
- Drives the same AHB-lite subordinates used elsewhere in the design, e.g. the SRAM adapters, from simple fabric-side masters such as DMA engines or debug bridges.

---
 rtl/ahbl_pkg.sv | 25 ++
 rtl/ahbl_req_manager.sv | 94 +++++++++
 2 files changed

// File: rtl/ahbl_pkg.sv
// Shared AHB-lite encodings and the transfer alignment helper.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  // addr_lsbs are the byte-lane address bits, zero-extended to 3 bits.
  function automatic logic is_aligned(input logic [2:0] addr_lsbs, input logic [2:0] size);
    logic ok;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = (addr_lsbs[0] == 1'b0);
      HSIZE_WORD: ok = (addr_lsbs[1:0] == 2'b00);
      default:    ok = (addr_lsbs == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahbl_req_manager.sv
// AHB-lite manager: turns a valid/ready request stream into pipelined single
// NONSEQ transfers and returns one in-order response per request.
module ahbl_req_manager
  import ahbl_pkg::*;
#(
  parameter int         W_ADDR    = 32,
  parameter int         W_DATA    = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [W_ADDR-1:0] req_addr,
  input  logic              req_write,
  input  logic [2:0]        req_size,
  input  logic [W_DATA-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [W_DATA-1:0] resp_rdata,
  output logic [W_ADDR-1:0] ahblm_haddr,
  output logic              ahblm_hwrite,
  output logic [1:0]        ahblm_htrans,
  output logic [2:0]        ahblm_hsize,
  output logic [2:0]        ahblm_hburst,
  output logic [3:0]        ahblm_hprot,
  output logic              ahblm_hmastlock,
  output logic [W_DATA-1:0] ahblm_hwdata,
  input  logic              ahblm_hready,
  input  logic              ahblm_hresp,
  input  logic [W_DATA-1:0] ahblm_hrdata
);

  localparam int W_LSB = $clog2(W_DATA / 8);

  // Handshake: a request transfers when req_valid && req_ready on a rising
  // clock edge; the payload must stay stable while req_valid waits.
  logic              r_active;
  logic              r_local_err;
  logic [W_DATA-1:0] r_wdata;

  logic [2:0] w_lsbs;
  logic       w_aligned;
  logic       w_err_cancel;
  logic       w_accept;
  logic       w_complete;

  always_comb begin
    w_lsbs = '0;
    for (int i = 0; i < W_LSB; i++) w_lsbs[i] = req_addr[i];
  end

  assign w_aligned    = is_aligned(w_lsbs, req_size);
  // First cycle of a two-cycle error response: the address phase must go IDLE.
  assign w_err_cancel = r_active && ahblm_hresp && !ahblm_hready;
  assign w_accept     = !rst && req_valid && ahblm_hready && !w_err_cancel;
  assign w_complete   = r_active && ahblm_hready;

  assign req_ready       = w_accept;
  assign ahblm_haddr     = req_addr;
  assign ahblm_hwrite    = req_write;
  assign ahblm_hsize     = req_size;
  assign ahblm_htrans    = (!rst && req_valid && w_aligned && !w_err_cancel) ?
                           HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahblm_hburst    = HBURST_SINGLE;
  assign ahblm_hprot     = HPROT_VAL;
  assign ahblm_hmastlock = 1'b0;
  assign ahblm_hwdata    = r_wdata;

  assign resp_valid = w_complete;
  assign resp_err   = w_complete && (ahblm_hresp || r_local_err);
  assign resp_rdata = ahblm_hrdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active    <= 1'b0;
      r_local_err <= 1'b0;
      r_wdata     <= '0;
    end else if (w_accept) begin
      // Misaligned requests still occupy a data phase so the local error
      // response stays in order with bus responses.
      r_active    <= 1'b1;
      r_local_err <= !w_aligned;
      r_wdata     <= req_wdata;
    end else if (w_complete) begin
      r_active    <= 1'b0;
      r_local_err <= 1'b0;
    end
  end

  a_legal_size : assert property (@(posedge clk) disable iff (rst)
    req_valid |-> (req_size <= 3'(W_LSB)));

endmodule
